// File: rtl/packet_check.sv
// ---------------------------------------------------------------------------
// packet_check
//
// Checks a stream of fixed-pattern test packets. Each packet is a header
// beat carrying a length code H in rx_data[7:0], then one all-ones beat,
// then all-zero beats, then a 64'haaaa... tail beat marked with eop.
// The module counts closed packets, counts the ones that had an error, and
// keeps sticky flags saying which kinds of error have been seen.
//
// Ports
//   sys_clk             : single clock, everything on the rising edge
//   sys_rst             : synchronous active-high reset
//   rx_data             : 64-bit beat data, qualified by rx_data_en
//   rx_data_en          : beat valid; other rx_* inputs ignored when low
//   rx_data_sop         : first beat of a packet
//   rx_data_eop         : last beat of a packet
//   rx_data_byte_vaild  : valid-byte code of the eop beat (recorded only)
//   count_clr           : synchronous clear of counters and sticky flags
//   pkt_ok / pkt_err    : one-cycle pulse after a packet closes
//   err_flags           : sticky flags [0] orphan, [1] sop mid-packet,
//                         [2] ones mismatch, [3] zero mismatch,
//                         [4] tail mismatch, [5] length error
//   pkt_cnt / err_cnt   : closed packets / closed packets with error
//   last_byte_vaild     : byte-valid code captured at the last eop close
// ---------------------------------------------------------------------------
module packet_check #(
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [63:0]      rx_data,
    input  logic             rx_data_en,
    input  logic             rx_data_sop,
    input  logic             rx_data_eop,
    input  logic [2:0]       rx_data_byte_vaild,
    input  logic             count_clr,
    output logic             pkt_ok,
    output logic             pkt_err,
    output logic [5:0]       err_flags,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       last_byte_vaild
);

    localparam logic [63:0] ONES_WORD = 64'hffff_ffff_ffff_ffff;
    localparam logic [63:0] ZERO_WORD = 64'h0;
    localparam logic [63:0] TAIL_WORD = 64'haaaa_aaaa_aaaa_aaaa;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t           r_state;
    logic [8:0]       r_beatIdx;
    logic [8:0]       r_numBeats;
    logic             r_pktErrLatch;
    logic             r_pktOk;
    logic             r_pktErr;
    logic [5:0]       r_errFlags;
    logic [CNT_W-1:0] r_pktCnt;
    logic [CNT_W-1:0] r_errCnt;
    logic [2:0]       r_lastByteVaild;

    logic [8:0]       w_hdr;
    logic [8:0]       w_hdrNumBeats;
    logic [8:0]       w_lastIdx;
    state_t           w_nextState;
    logic [8:0]       w_nextIdx;
    logic [8:0]       w_nextNumBeats;
    logic             w_nextLatch;
    logic [5:0]       w_flagSet;
    logic [1:0]       w_closeCnt;
    logic [1:0]       w_closeErrCnt;
    logic             w_eopClose;

    assign w_hdr     = {1'b0, rx_data[7:0]};
    assign w_lastIdx = r_numBeats - 9'd1;

    // Turn the header code into a beat count. The 9-bit width keeps H+121
    // (at most 220) from overflowing; the total beat count is length + 1.
    always_comb begin
        if (w_hdr < 9'd100) begin
            w_hdrNumBeats = w_hdr + 9'd121;
        end else if (w_hdr > 9'd253) begin
            w_hdrNumBeats = w_hdr - 9'd2;
        end else begin
            w_hdrNumBeats = w_hdr + 9'd1;
        end
    end

    // Decode a single beat against the current state. This block produces
    // the next state, the error bits raised by this beat, and how many
    // packets this beat closes. A sop seen inside a packet closes the old
    // packet as errored and is then handled as a fresh header. If that
    // header also has eop, one beat closes two packets, so the close
    // counts are two bits wide.
    always_comb begin
        w_nextState    = r_state;
        w_nextIdx      = r_beatIdx;
        w_nextNumBeats = r_numBeats;
        w_nextLatch    = r_pktErrLatch;
        w_flagSet      = 6'b0;
        w_closeCnt     = 2'd0;
        w_closeErrCnt  = 2'd0;
        w_eopClose     = 1'b0;

        if (rx_data_en) begin
            if (rx_data_sop) begin
                if (r_state != IDLE) begin
                    w_flagSet[1]  = 1'b1;
                    w_closeCnt    = 2'd1;
                    w_closeErrCnt = 2'd1;
                end
                if (rx_data_eop) begin
                    w_flagSet[5]  = 1'b1;
                    w_closeCnt    = w_closeCnt + 2'd1;
                    w_closeErrCnt = w_closeErrCnt + 2'd1;
                    w_eopClose    = 1'b1;
                    w_nextState   = IDLE;
                    w_nextIdx     = 9'd0;
                    w_nextLatch   = 1'b0;
                end else begin
                    w_nextState    = BODY;
                    w_nextIdx      = 9'd1;
                    w_nextNumBeats = w_hdrNumBeats;
                    w_nextLatch    = 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        w_flagSet[0] = 1'b1;
                    end
                    BODY: begin
                        if (rx_data_eop) begin
                            if (r_beatIdx == w_lastIdx) begin
                                w_flagSet[4] = (rx_data != TAIL_WORD);
                            end else begin
                                w_flagSet[5] = 1'b1;
                            end
                            w_closeCnt    = 2'd1;
                            w_closeErrCnt = (r_pktErrLatch || (w_flagSet != 6'b0)) ? 2'd1 : 2'd0;
                            w_eopClose    = 1'b1;
                            w_nextState   = IDLE;
                            w_nextIdx     = 9'd0;
                            w_nextLatch   = 1'b0;
                        end else if (r_beatIdx == w_lastIdx) begin
                            w_flagSet[5] = 1'b1;
                            w_nextLatch  = 1'b1;
                            w_nextState  = DROP;
                        end else begin
                            if (r_beatIdx == 9'd1) begin
                                w_flagSet[2] = (rx_data != ONES_WORD);
                            end else begin
                                w_flagSet[3] = (rx_data != ZERO_WORD);
                            end
                            w_nextLatch = r_pktErrLatch || (w_flagSet != 6'b0);
                            w_nextIdx   = r_beatIdx + 9'd1;
                        end
                    end
                    DROP: begin
                        if (rx_data_eop) begin
                            w_closeCnt    = 2'd1;
                            w_closeErrCnt = 2'd1;
                            w_eopClose    = 1'b1;
                            w_nextState   = IDLE;
                            w_nextIdx     = 9'd0;
                            w_nextLatch   = 1'b0;
                        end
                    end
                    default: begin
                        w_nextState = IDLE;
                    end
                endcase
            end
        end
    end

    // State register plus all registered outputs. count_clr only touches
    // the statistics: the packet walk carries on, and any close or flag
    // that lands in the same cycle as the clear is dropped.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state         <= IDLE;
            r_beatIdx       <= 9'd0;
            r_numBeats      <= 9'd0;
            r_pktErrLatch   <= 1'b0;
            r_pktOk         <= 1'b0;
            r_pktErr        <= 1'b0;
            r_errFlags      <= 6'b0;
            r_pktCnt        <= '0;
            r_errCnt        <= '0;
            r_lastByteVaild <= 3'b0;
        end else begin
            r_state       <= w_nextState;
            r_beatIdx     <= w_nextIdx;
            r_numBeats    <= w_nextNumBeats;
            r_pktErrLatch <= w_nextLatch;
            if (count_clr) begin
                r_pktOk         <= 1'b0;
                r_pktErr        <= 1'b0;
                r_errFlags      <= 6'b0;
                r_pktCnt        <= '0;
                r_errCnt        <= '0;
                r_lastByteVaild <= 3'b0;
            end else begin
                r_pktOk    <= (w_closeCnt != 2'd0) && (w_closeErrCnt == 2'd0);
                r_pktErr   <= (w_closeErrCnt != 2'd0);
                r_errFlags <= r_errFlags | w_flagSet;
                r_pktCnt   <= r_pktCnt + CNT_W'(w_closeCnt);
                r_errCnt   <= r_errCnt + CNT_W'(w_closeErrCnt);
                if (w_eopClose) begin
                    r_lastByteVaild <= rx_data_byte_vaild;
                end
            end
        end
    end

    assign pkt_ok          = r_pktOk;
    assign pkt_err         = r_pktErr;
    assign err_flags       = r_errFlags;
    assign pkt_cnt         = r_pktCnt;
    assign err_cnt         = r_errCnt;
    assign last_byte_vaild = r_lastByteVaild;

endmodule
